// File: rtl/mc_mem_bram_if.sv
// mc_mem_bram_if: the mi_* burst bus between an initiator (mc_core or a bench)
// and the mc_mem_bram responder. The master drives commands and write data.
// The slave drives the command accept, the write-beat acks and the read beats.
interface mc_mem_bram_if #(
  parameter int ADDR_WIDTH = 20
);
  logic [ADDR_WIDTH-1:0] mi_addr;
  logic [6:0]            mi_len;
  logic                  mi_rw;
  logic                  mi_valid;
  logic                  mi_ready;
  logic [31:0]           mi_wdata;
  logic                  mi_wack;
  logic                  mi_wlast;
  logic [31:0]           mi_rdata;
  logic                  mi_rstb;
  logic                  mi_rlast;

  modport master (
    output mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
    input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );

  modport slave (
    input  mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
    output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );
endinterface

// File: rtl/mc_mem_bram.sv
// mc_mem_bram: memory-side responder for the mi_* burst bus. It serves read
// and write bursts of 1..128 words from an inferred on-chip RAM with
// 2**MEM_AW words. Addresses wrap modulo the RAM depth.
//
// Optional feature: define MC_MEM_BRAM_STALL_EN to insert pseudo-random beat
// gaps. A 16-bit LFSR drives the gaps, so an initiator's flow control gets
// exercised. Without the macro, beats run strictly back-to-back.
//
// Every output is a register. The write-beat ack is registered from the
// next-state decision. The read beat comes from the synchronous RAM read
// one cycle after the read is issued.
module mc_mem_bram #(
  parameter int ADDR_WIDTH = 20,
  parameter int MEM_AW     = 10,
  parameter int CMD_LAT    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_mem_bram_if.slave  mi
);

  localparam int DEPTH = 1 << MEM_AW;

  // The LAT state counts from CMD_LAT-1 down to 0. CMD_LAT=0 never enters LAT.
  localparam logic [3:0] LAT_LOAD = (CMD_LAT > 0) ? 4'(CMD_LAT - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAT,
    S_WR,
    S_RD,
    S_RD_TAIL
  } state_t;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [3:0]        lat_q, lat_d;

  logic              ready_q, ready_d;
  logic              wack_q, wack_d;
  logic              wlast_q, wlast_d;
  logic              rstb_q, rstb_d;
  logic              rlast_q, rlast_d;
  logic [31:0]       rdata_q;

  logic              handshake;
  logic              wr_beat;
  logic              rd_beat;
  logic              beat_ok;      // the current WR/RD cycle may move a beat
  logic              beat_ok_nxt;  // the same permission for the next cycle

  logic [31:0]       mem [DEPTH];

  // Only the low MEM_AW address bits select a word. The rest are deliberately dropped.
  generate
    if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mi.mi_addr[ADDR_WIDTH-1:MEM_AW];
    end
  endgenerate

`ifdef MC_MEM_BRAM_STALL_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1. lfsr_q governs the current cycle.
  logic [15:0] lfsr_q, lfsr_nxt;
  logic        in_burst;

  assign in_burst    = (state_q == S_WR) || (state_q == S_RD);
  assign lfsr_nxt    = in_burst ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                                : lfsr_q;
  assign beat_ok     = (lfsr_q[1:0] != 2'b00);
  assign beat_ok_nxt = (lfsr_nxt[1:0] != 2'b00);

  // Advance the stall LFSR on every burst cycle. It reseeds on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_nxt;
  end
`else
  assign beat_ok     = 1'b1;
  assign beat_ok_nxt = 1'b1;
`endif

  // ready_q is low for one cycle after reset, so handshake must gate on it.
  assign handshake = (state_q == S_IDLE) && mi.mi_valid && ready_q;
  assign wr_beat   = (state_q == S_WR) && beat_ok;
  assign rd_beat   = (state_q == S_RD) && beat_ok;

  // Decide the next state and the burst bookkeeping (address, remaining beats, latency).
  always_comb begin
    // NOTE: every variable gets a default first. This makes paths that do not
    // assign it hold the value rather than infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    lat_d   = lat_q;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          addr_d = mi.mi_addr[MEM_AW-1:0];
          cnt_d  = mi.mi_len;
          rw_d   = mi.mi_rw;
          lat_d  = LAT_LOAD;
          if (CMD_LAT == 0) state_d = mi.mi_rw ? S_RD : S_WR;
          else              state_d = S_LAT;
        end
      end

      S_LAT: begin
        if (lat_q == 4'd0) state_d = rw_q ? S_RD : S_WR;
        else               lat_d   = lat_q - 4'd1;
      end

      S_WR: begin
        if (wr_beat) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 7'd1;
          if (cnt_q == 7'd0) state_d = S_IDLE;
        end
      end

      S_RD: begin
        if (rd_beat) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 7'd1;
          if (cnt_q == 7'd0) state_d = S_RD_TAIL;
        end
      end

      S_RD_TAIL: state_d = S_IDLE;

      default:   state_d = S_IDLE;
    endcase
  end

  // Compute next-cycle values of the registered bus outputs from the next state.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    wack_d  = (state_d == S_WR) && beat_ok_nxt;
    wlast_d = wack_d && (cnt_d == 7'd0);
    rstb_d  = rd_beat;
    rlast_d = rd_beat && (cnt_q == 7'd0);
  end

  // Burst control registers. Reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      lat_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from the pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      lat_q   <= lat_d;
    end
  end

  // Registered bus outputs. mi_rdata changes only on an issued read, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      wack_q  <= 1'b0;
      wlast_q <= 1'b0;
      rstb_q  <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      wack_q  <= wack_d;
      wlast_q <= wlast_d;
      rstb_q  <= rstb_d;
      rlast_q <= rlast_d;
      if (rd_beat) rdata_q <= mem[addr_q];
    end
  end

  // RAM write port. A write happens at the end of each cycle whose beat is acked.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset. Contents survive rst_n, and the array
    // still maps onto block RAM.
    if (wr_beat) mem[addr_q] <= mi.mi_wdata;
  end

  assign mi.mi_ready = ready_q;
  assign mi.mi_wack  = wack_q;
  assign mi.mi_wlast = wlast_q;
  assign mi.mi_rstb  = rstb_q;
  assign mi.mi_rlast = rlast_q;
  assign mi.mi_rdata = rdata_q;

endmodule

// File: tb/tb_mc_mem_bram.sv
// tb_mc_mem_bram: bench for mc_mem_bram.
// A word-array reference memory in the bench supplies the expected read data.
// Each accepted command pushes its expected beats, with data, last flag and
// earliest cycle, into a queue. A negedge monitor pops one entry for every
// beat the DUT presents.
`timescale 1ns/1ps
module tb_mc_mem_bram;

  localparam int ADDR_WIDTH = 20;
  localparam int MEM_AW     = 10;
  localparam int CMD_LAT    = 2;
  localparam int DEPTH      = 1 << MEM_AW;

  typedef logic [31:0] word_q_t [$];

  typedef struct {
    logic [31:0] data;
    logic        last;
    int unsigned cyc;
  } rexp_t;

  typedef struct {
    logic        last;
    int unsigned cyc;
  } wexp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mc_mem_bram_if #(.ADDR_WIDTH(ADDR_WIDTH)) mi ();

  mc_mem_bram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_AW    (MEM_AW),
    .CMD_LAT   (CMD_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mi   (mi)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  logic [31:0] ref_mem [DEPTH];
  rexp_t       rq[$];
  wexp_t       wq[$];
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle timing is exact without stalls. With stalls it is only a lower bound.
  task automatic check_cyc(input string name, input int unsigned act, input int unsigned exp);
`ifdef MC_MEM_BRAM_STALL_EN
    n_tests++;
    if (act < exp) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d, expected at least %0d", name, act, exp);
    end
`else
    check(name, act, exp);
`endif
  endtask

  // Monitor: compare every presented beat against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rdata = '0;
    end else begin
      if (mi.mi_rstb) begin
        if (rq.size() == 0) begin
          check("rstb_unexpected", 32'(mi.mi_rstb), 32'd0);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          check("rdata", mi.mi_rdata, e.data);
          check("rlast", 32'(mi.mi_rlast), 32'(e.last));
          check_cyc("rstb_cycle", cyc, e.cyc);
        end
        last_rdata = mi.mi_rdata;
      end else begin
        check("rdata_hold", mi.mi_rdata, last_rdata);
        check("rlast_without_rstb", 32'(mi.mi_rlast), 32'd0);
      end

      if (mi.mi_wack) begin
        if (wq.size() == 0) begin
          check("wack_unexpected", 32'(mi.mi_wack), 32'd0);
        end else begin
          wexp_t w;
          w = wq.pop_front();
          check("wlast", 32'(mi.mi_wlast), 32'(w.last));
          check_cyc("wack_cycle", cyc, w.cyc);
        end
      end else begin
        check("wlast_without_wack", 32'(mi.mi_wlast), 32'd0);
      end
    end
  end

  function automatic int wrap_addr(input logic [ADDR_WIDTH-1:0] addr, input int i);
    return (int'(addr) + i) % DEPTH;
  endfunction

  // Present a command. Once it is accepted, push the expected beats. Returns
  // just after the accepting edge, with valid still high.
  task automatic send_cmd(input logic rw, input logic [ADDR_WIDTH-1:0] addr, input logic [6:0] len,
                          output int unsigned t_acc, output bit ok);
    int n = 0;
    @(negedge clk);
    mi.mi_valid = 1'b1;
    mi.mi_rw    = rw;
    mi.mi_addr  = addr;
    mi.mi_len   = len;
    while (!mi.mi_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!mi.mi_ready) begin
      check("cmd_accept_timeout", 32'(mi.mi_ready), 32'd1);
      mi.mi_valid = 1'b0;
      t_acc = cyc;
      ok = 1'b0;
      return;
    end
    ok    = 1'b1;
    t_acc = cyc + 1;
    for (int i = 0; i <= int'(len); i++) begin
      if (rw) begin
        rexp_t e;
        e.data = ref_mem[wrap_addr(addr, i)];
        e.last = (i == int'(len));
        e.cyc  = t_acc + CMD_LAT + 1 + i;
        rq.push_back(e);
      end else begin
        wexp_t w;
        w.last = (i == int'(len));
        w.cyc  = t_acc + CMD_LAT + i;
        wq.push_back(w);
      end
    end
    @(posedge clk);
    #1 check("ready_drop_after_accept", 32'(mi.mi_ready), 32'd0);
  endtask

  // Write a burst. Each word is presented until its beat is acked.
  // abort_at >= 0 asserts reset once that many beats have been consumed.
  task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [6:0] len,
                          input word_q_t data, input int abort_at);
    int unsigned t;
    bit ok;
    int idx = 0;
    int n   = 0;
    send_cmd(1'b0, addr, len, t, ok);
    if (!ok) return;
    while (idx <= int'(len) && n < 4000) begin
      @(negedge clk);
      n++;
      mi.mi_valid = 1'b0;
      if (idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(mi.mi_ready), 32'd0);
        check("rst_mid_wack",  32'(mi.mi_wack),  32'd0);
        check("rst_mid_wlast", 32'(mi.mi_wlast), 32'd0);
        check("rst_mid_rstb",  32'(mi.mi_rstb),  32'd0);
        check("rst_mid_rlast", 32'(mi.mi_rlast), 32'd0);
        check("rst_mid_rdata", mi.mi_rdata,      32'd0);
        rq.delete();
        wq.delete();
        return;
      end
      mi.mi_wdata = data[idx];
      if (mi.mi_wack) begin
        ref_mem[wrap_addr(addr, idx)] = data[idx];
        idx++;
      end
    end
    if (idx <= int'(len)) check("write_beats_timeout", 32'(idx), 32'(int'(len) + 1));
  endtask

  task automatic do_read(input logic [ADDR_WIDTH-1:0] addr, input logic [6:0] len,
                         input bit keep, output int unsigned t_acc);
    bit ok;
    send_cmd(1'b1, addr, len, t_acc, ok);
    if (!keep) begin
      @(negedge clk);
      mi.mi_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || !mi.mi_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_beats", 32'(rq.size() + wq.size()), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_low_before_first_edge", 32'(mi.mi_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(mi.mi_ready), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_q_t     d;
    int unsigned t1, t2;

    mi.mi_valid = 1'b0;
    mi.mi_rw    = 1'b0;
    mi.mi_addr  = '0;
    mi.mi_len   = '0;
    mi.mi_wdata = '0;

    // Reset: hold for 10 cycles, check every output is zero, then release.
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_ready", 32'(mi.mi_ready), 32'd0);
    check("rst_wack",  32'(mi.mi_wack),  32'd0);
    check("rst_wlast", 32'(mi.mi_wlast), 32'd0);
    check("rst_rstb",  32'(mi.mi_rstb),  32'd0);
    check("rst_rlast", 32'(mi.mi_rlast), 32'd0);
    check("rst_rdata", mi.mi_rdata,      32'd0);
    release_reset();

    // Fill the whole RAM with random words using maximum-length bursts.
    for (int b = 0; b < DEPTH / 128; b++) begin
      d.delete();
      for (int i = 0; i < 128; i++) d.push_back($urandom);
      do_write(ADDR_WIDTH'(b * 128), 7'd127, d, -1);
    end
    wait_drain();

    // 16-beat burst with data 0x1000+i, then read it back.
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back(32'h1000 + 32'(i));
    do_write(20'h00010, 7'd15, d, -1);
    do_read(20'h00010, 7'd15, 1'b0, t1);
    wait_drain();

    // Single-beat burst.
    d.delete();
    d.push_back(32'h600dbabe);
    do_write(20'h0001f, 7'd0, d, -1);
    do_read(20'h0001f, 7'd0, 1'b0, t1);
    wait_drain();

    // Wrap past the top of the RAM. Upper address bits are ignored on the read.
    d.delete();
    d.push_back(32'h0000000A);
    d.push_back(32'h0000000B);
    do_write(20'h003FF, 7'd1, d, -1);
    do_read(20'h403FF, 7'd1, 1'b0, t1);
    wait_drain();
    check("wrap_model_low",  ref_mem[0],         32'h0000000B);
    check("wrap_model_high", ref_mem[DEPTH - 1], 32'h0000000A);

    // Back-to-back reads with valid held: the second waits for the first to finish.
    do_read(20'h00100, 7'd3, 1'b1, t1);
    do_read(20'h00200, 7'd2, 1'b0, t2);
    check_cyc("b2b_read_spacing", t2 - t1, 32'(CMD_LAT + 4 + 2));
    wait_drain();

    // Randomized mix of commands.
    for (int k = 0; k < 30; k++) begin
      logic [ADDR_WIDTH-1:0] a;
      logic [6:0]            l;
      a = ADDR_WIDTH'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_read(a, l, 1'($urandom_range(0, 1)), t1);
      end else begin
        d.delete();
        for (int i = 0; i <= int'(l); i++) d.push_back($urandom);
        do_write(a, l, d, -1);
      end
    end
    @(negedge clk);
    mi.mi_valid = 1'b0;
    wait_drain();

    // Reset partway through a 16-beat write, after 5 beats have been consumed.
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back($urandom);
    do_write(20'h00300, 7'd15, d, 5);
    repeat (3) @(negedge clk);
    release_reset();
    do_read(20'h00300, 7'd15, 1'b0, t1);
    wait_drain();

    // Full-length read across the region written during the fill.
    do_read(20'h00080, 7'd127, 1'b0, t1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
